// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg
// Shared UART definitions for the MMIO window at address nibble 4'b0101.
// Holds the register map, the supported line rates, the control word
// layout, the frame state enum shared by the TX and RX state machines, and
// the divider helper that turns a clock frequency and line rate into
// clock cycles per bit.
package uart_mmio_pkg;

  localparam int unsigned UART_SIZE = 12;

  typedef enum logic [1:0] {
    UART_CTRL = 2'd0,
    UART_RX   = 2'd1,
    UART_TX   = 2'd2
  } uart_addr_t;

  typedef enum int unsigned {
    BR_9600   = 9600,
    BR_19200  = 19200,
    BR_57600  = 57600,
    BR_115200 = 115200,
    BR_921600 = 921600
  } uart_baud_rate_t;

  typedef struct packed {
    logic [29:0] reserved;
    logic        rx_valid;
    logic        tx_ready;
  } uart_ctrl_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_frame_state_t;

  // Rounded-to-nearest clock cycles per bit.
  function automatic int unsigned uartDiv(input int unsigned clkHz,
                                          input int unsigned baud);
    return (clkHz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
// 8N1 receiver: synchronises the asynchronous serial line, validates the
// start bit at half a bit period, samples each data bit and the stop bit
// in the middle of its period and reports the completed frame.
// Ports:
//   clk_i      core clock
//   rst_ni     active-low asynchronous reset
//   rx_i       raw serial input (asynchronous to clk_i)
//   done_o     one-cycle pulse on the stop sample edge when the stop bit is 1
//   frameErr_o one-cycle pulse on the stop sample edge when the stop bit is 0
//   byte_o     received byte, valid while done_o is high
module uart_rx_deser
  import uart_mmio_pkg::*;
#(
  parameter int unsigned DIV = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       done_o,
  output logic       frameErr_o,
  output logic [7:0] byte_o
);

  localparam int unsigned CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]        sync_q;
  logic              rxPrev_q;
  logic              rxS;
  logic              rxFall;
  uart_frame_state_t state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shift_q, shift_d;

  assign rxS    = sync_q[1];
  assign rxFall = rxPrev_q & ~rxS;
  assign byte_o = shift_q;

  // Synchroniser resets to the idle-high line level so that releasing
  // reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      rxPrev_q <= 1'b1;
      state_q  <= UART_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      sync_q   <= {sync_q[0], rx_i};
      rxPrev_q <= rxS;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  // The start bit is re-checked half a bit after the edge; from then on
  // every sample is a full bit period apart, landing mid-bit. Data bits
  // shift in from the top so bit 0 ends up in shift_q[0].
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    done_o     = 1'b0;
    frameErr_o = 1'b0;
    case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
        if (rxFall) begin
          state_d = UART_START;
          cnt_d   = HALF_LAST;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          if (rxS) begin
            state_d = UART_IDLE;
            cnt_d   = '0;
          end else begin
            state_d  = UART_DATA;
            cnt_d    = BIT_LAST;
            bitIdx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxS, shift_q[7:1]};
          cnt_d   = BIT_LAST;
          if (bitIdx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) begin
          state_d    = UART_IDLE;
          cnt_d      = '0;
          done_o     = rxS;
          frameErr_o = ~rxS;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = UART_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio
// Memory-mapped 8N1 UART with a three-register window {ctrl, rx_data,
// tx_data}. Contains the register decode and the TX serializer; the
// receiver lives in uart_rx_deser.
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (always ready)
//   req_we/addr/wdata   request type, byte offset, write data
//   rsp_valid/rsp_data  read response, one cycle after the read is accepted
//   uart_rx_i           serial input, asynchronous to clk
//   uart_tx_o           serial output, idle high
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned     CLK_FREQ_HZ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE   = BR_115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        uart_rx_i,
  output logic        uart_tx_o
);

  localparam int unsigned DIV = uartDiv(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DIV < 4) begin : gDivTooSmall
    $error("uart_mmio: baud divider must be at least 4 clock cycles per bit");
  end

  logic [1:0]        rstSync_q;
  logic              rstnInt;
  uart_frame_state_t txState_q, txState_d;
  logic [CW-1:0]     txCnt_q, txCnt_d;
  logic [2:0]        txBitIdx_q, txBitIdx_d;
  logic [7:0]        txByte_q, txByte_d;
  logic              txOut_q, txOut_d;
  logic              txReady_q, txReady_d;
  logic [7:0]        rxByte_q, rxByte_d;
  logic              rxValid_q, rxValid_d;
  logic              rspValid_d;
  logic [31:0]       rspData_d;
  logic              rspValid_q;
  logic [31:0]       rspData_q;
  logic              txWrite;
  logic              rxRead;
  logic              rxDone;
  logic              rxFrameErr;
  logic [7:0]        rxByteNew;
  logic [31:0]       readData;
  uart_ctrl_t        ctrlWord;
  logic              unusedBits;

  assign req_ready = 1'b1;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign uart_tx_o = txOut_q;
  assign rstnInt   = rstSync_q[1];

  assign unusedBits = ^{req_addr[1:0], req_wdata[31:8], rxFrameErr};

  // Reset asserts everywhere the moment rst_n falls but releases two
  // clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  uart_rx_deser #(
    .DIV(DIV)
  ) uRxDeser (
    .clk_i     (clk),
    .rst_ni    (rstnInt),
    .rx_i      (uart_rx_i),
    .done_o    (rxDone),
    .frameErr_o(rxFrameErr),
    .byte_o    (rxByteNew)
  );

  // A TX write only lands while the serializer is idle; writes arriving
  // while busy, including on the cycle tx_ready re-asserts, are dropped.
  assign txWrite = req_valid & req_we & (req_addr[3:2] == UART_TX) & txReady_q;
  assign rxRead  = req_valid & ~req_we & (req_addr[3:2] == UART_RX);

  assign ctrlWord = '{reserved: '0, rx_valid: rxValid_q, tx_ready: txReady_q};

  always_comb begin
    readData = '0;
    case (req_addr[3:2])
      UART_CTRL: readData = ctrlWord;
      UART_RX:   readData = {24'b0, rxByte_q};
      default:   readData = '0;
    endcase
  end

  // A completed frame wins over a same-cycle RX read: the read returns the
  // old byte while the new byte is stored and rx_valid stays set.
  always_comb begin
    rspValid_d = req_valid & ~req_we;
    rspData_d  = rspValid_d ? readData : rspData_q;
    rxByte_d   = rxDone ? rxByteNew : rxByte_q;
    rxValid_d  = rxDone ? 1'b1 : (rxRead ? 1'b0 : rxValid_q);
  end

  // Serializer: every bit, start and stop included, is held for DIV cycles.
  // The line register updates on the accept edge so the start bit begins
  // the following cycle.
  always_comb begin
    txState_d  = txState_q;
    txCnt_d    = txCnt_q;
    txBitIdx_d = txBitIdx_q;
    txByte_d   = txByte_q;
    txOut_d    = txOut_q;
    txReady_d  = txReady_q;
    case (txState_q)
      UART_IDLE: begin
        txCnt_d = '0;
        if (txWrite) begin
          txState_d = UART_START;
          txCnt_d   = BIT_LAST;
          txByte_d  = req_wdata[7:0];
          txOut_d   = 1'b0;
          txReady_d = 1'b0;
        end
      end
      UART_START: begin
        if (txCnt_q == '0) begin
          txState_d  = UART_DATA;
          txCnt_d    = BIT_LAST;
          txBitIdx_d = '0;
          txOut_d    = txByte_q[0];
        end else begin
          txCnt_d = txCnt_q - CNT_ONE;
        end
      end
      UART_DATA: begin
        if (txCnt_q == '0) begin
          txCnt_d = BIT_LAST;
          if (txBitIdx_q == 3'd7) begin
            txState_d = UART_STOP;
            txOut_d   = 1'b1;
          end else begin
            txBitIdx_d = txBitIdx_q + 3'd1;
            txOut_d    = txByte_q[txBitIdx_q + 3'd1];
          end
        end else begin
          txCnt_d = txCnt_q - CNT_ONE;
        end
      end
      UART_STOP: begin
        if (txCnt_q == '0) begin
          txState_d = UART_IDLE;
          txCnt_d   = '0;
          txReady_d = 1'b1;
        end else begin
          txCnt_d = txCnt_q - CNT_ONE;
        end
      end
      default: begin
        txState_d = UART_IDLE;
        txCnt_d   = '0;
        txOut_d   = 1'b1;
        txReady_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstnInt) begin
    if (!rstnInt) begin
      txState_q  <= UART_IDLE;
      txCnt_q    <= '0;
      txBitIdx_q <= '0;
      txByte_q   <= '0;
      txOut_q    <= 1'b1;
      txReady_q  <= 1'b1;
      rxByte_q   <= '0;
      rxValid_q  <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
    end else begin
      txState_q  <= txState_d;
      txCnt_q    <= txCnt_d;
      txBitIdx_q <= txBitIdx_d;
      txByte_q   <= txByte_d;
      txOut_q    <= txOut_d;
      txReady_q  <= txReady_d;
      rxByte_q   <= rxByte_d;
      rxValid_q  <= rxValid_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio
// Directed bench for uart_mmio at DIV = 8 (7.3728 MHz clock, 921600 baud).
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_uart_mmio;
  import uart_mmio_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [3:0]  req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        uart_rx_i = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        uart_tx_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        expValid;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  uart_mmio #(
    .CLK_FREQ_HZ(7_372_800),
    .BAUD_RATE  (BR_921600)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .uart_rx_i(uart_rx_i),
    .uart_tx_o(uart_tx_o)
  );

  // One accepted request; returns on the falling edge after the accept,
  // where the read response (if any) is visible.
  task automatic applyStimulus(input logic we, input logic [3:0] addr,
                               input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkRead(input string name, input logic [3:0] addr,
                           input logic [31:0] expected);
    applyStimulus(1'b0, addr, 32'h0);
    checkOutput({name, "_valid"}, {31'b0, rsp_valid}, 32'h1);
    checkOutput(name, rsp_data, expected);
  endtask

  // Writes a TX byte and follows the whole frame sample by sample while
  // polling CTRL every cycle. Optionally fires a second TX write two cycles
  // after the first, which must be dropped.
  task automatic txFrame(input logic [7:0] b, input bit secondWrite,
                         input string name);
    logic [9:0] bits;
    logic [9:0] mid;
    int         lineErr;
    bits    = {1'b1, b, 1'b0};
    mid     = '0;
    lineErr = 0;
    applyStimulus(1'b1, 4'h8, {24'h0, b});
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'h0;
    for (int k = 0; k < 82; k++) begin
      if (k < 80) begin
        if (uart_tx_o !== bits[k / 8]) lineErr++;
        if ((k % 8) == 4) mid[k / 8] = uart_tx_o;
      end
      if (k == 80) checkOutput({name, "_ctrlBusy"}, rsp_data, 32'h0);
      if (k == 81) checkOutput({name, "_ctrlReady"}, rsp_data, 32'h1);
      if (secondWrite && k == 1) begin
        req_we    = 1'b1;
        req_addr  = 4'h8;
        req_wdata = 32'h22;
      end
      if (secondWrite && k == 2) begin
        checkOutput({name, "_wrNoRsp"}, {31'b0, rsp_valid}, 32'h0);
        req_we   = 1'b0;
        req_addr = 4'h0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput({name, "_lineErrs"}, lineErr, 32'h0);
    checkOutput({name, "_midBits"}, {22'b0, mid}, {22'b0, bits});
  endtask

  task automatic rxFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = bits[i];
      repeat (8) @(negedge clk);
    end
    uart_rx_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idleErr;

    vecs[0] = '{we: 1'b0, addr: 4'h0, wdata: 32'h0,        expValid: 1'b1, expData: 32'h1};
    vecs[1] = '{we: 1'b0, addr: 4'h4, wdata: 32'h0,        expValid: 1'b1, expData: 32'h0};
    vecs[2] = '{we: 1'b0, addr: 4'h8, wdata: 32'h0,        expValid: 1'b1, expData: 32'h0};
    vecs[3] = '{we: 1'b0, addr: 4'hC, wdata: 32'h0,        expValid: 1'b1, expData: 32'h0};
    vecs[4] = '{we: 1'b0, addr: 4'h2, wdata: 32'h0,        expValid: 1'b1, expData: 32'h1};
    vecs[5] = '{we: 1'b1, addr: 4'h0, wdata: 32'hFFFFFFFF, expValid: 1'b0, expData: 32'h1};
    vecs[6] = '{we: 1'b1, addr: 4'h4, wdata: 32'h000000FF, expValid: 1'b0, expData: 32'h1};
    vecs[7] = '{we: 1'b1, addr: 4'hC, wdata: 32'h000000AB, expValid: 1'b0, expData: 32'h1};
    vecs[8] = '{we: 1'b0, addr: 4'h0, wdata: 32'h0,        expValid: 1'b1, expData: 32'h1};
    vecs[9] = '{we: 1'b0, addr: 4'h4, wdata: 32'h0,        expValid: 1'b1, expData: 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstTx", {31'b0, uart_tx_o}, 32'h1);
    checkOutput("rstRspValid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("rstRspData", rsp_data, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reqReady", {31'b0, req_ready}, 32'h1);

    // Register decode table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_valid", i), {31'b0, rsp_valid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_data", i), rsp_data, vecs[i].expData);
    end

    // TX frame 0xA5
    txFrame(8'hA5, 1'b0, "txA5");

    // RX frame 0x3C
    rxFrame(8'h3C, 1'b1);
    checkRead("rx3cCtrl", 4'h0, 32'h3);
    checkRead("rx3cData", 4'h4, 32'h3C);
    checkRead("rx3cCtrlAfter", 4'h0, 32'h1);

    // TX 0x11 with a dropped second write
    txFrame(8'h11, 1'b1, "tx11");
    idleErr = 0;
    for (int k = 0; k < 90; k++) begin
      if (uart_tx_o !== 1'b1) idleErr++;
      @(negedge clk);
    end
    checkOutput("tx22Dropped", idleErr, 32'h0);
    checkRead("tx11Ctrl", 4'h0, 32'h1);

    // Framing error and glitch
    rxFrame(8'h55, 1'b0);
    checkRead("frameErrCtrl", 4'h0, 32'h1);
    checkRead("frameErrData", 4'h4, 32'h3C);
    uart_rx_i = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (20) @(negedge clk);
    checkRead("glitchCtrl", 4'h0, 32'h1);
    checkRead("glitchData", 4'h4, 32'h3C);
    rxFrame(8'h96, 1'b1);
    checkRead("rx96Ctrl", 4'h0, 32'h3);
    checkRead("rx96Data", 4'h4, 32'h96);

    // Reset during bit 4 of a TX 0xFF frame
    applyStimulus(1'b1, 4'h8, 32'hFF);
    repeat (43) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstTx", {31'b0, uart_tx_o}, 32'h1);
    checkOutput("midRstRspValid", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkRead("postRstCtrl", 4'h0, 32'h1);
    txFrame(8'h0F, 1'b0, "tx0F");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
